// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects the next fetch address and
// loads the IF/ID pipeline register with stall and bubble control.
module if_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INST_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 32'h0000_012C,
  parameter logic [INST_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_instr,
  input  logic                  stall_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  trap_req,
  input  logic                  mret_req,
  input  logic [ADDR_WIDTH-1:0] mepc,
  output logic [ADDR_WIDTH-1:0] pc_f,
  output logic [ADDR_WIDTH-1:0] pc_d,
  output logic [ADDR_WIDTH-1:0] pc_plus4_d,
  output logic [INST_WIDTH-1:0] instr_d,
  output logic                  valid_d,
  output logic                  misaligned_f
);

  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] raw_target;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  redirect;
  logic                  misaligned_q;

  assign redirect = trap_req | mret_req | branch_taken;
  assign pc_plus4 = pc_q + FOUR;  // wraps modulo 2^ADDR_WIDTH

  // Redirect source priority: trap entry, then mret return, then branch.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    raw_target = branch_target;
    if (trap_req)      raw_target = TRAP_VECTOR;
    else if (mret_req) raw_target = mepc;
  end

  always_comb begin
    pc_next = pc_plus4;
    if (redirect)     pc_next = {raw_target[ADDR_WIDTH-1:2], 2'b00};
    else if (stall_f) pc_next = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      pc_q         <= pc_next;
      misaligned_q <= redirect && (raw_target[1:0] != 2'b00);
    end
  end

  // IF/ID register; a redirect squashes the wrong-path fetch even under stall_d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_d       <= '0;
      pc_plus4_d <= FOUR;
      instr_d    <= NOP_INSTR;
      valid_d    <= 1'b0;
    end else if (redirect || flush_d) begin
      pc_d       <= pc_q;
      pc_plus4_d <= pc_plus4;
      instr_d    <= NOP_INSTR;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      pc_d       <= pc_q;
      pc_plus4_d <= pc_plus4;
      instr_d    <= imem_instr;
      valid_d    <= 1'b1;
    end
  end

  assign imem_addr    = pc_q;
  assign pc_f         = pc_q;
  assign misaligned_f = misaligned_q;

endmodule
